adxl345_uart_reporter: RTL

//   Downstream consumer of the ADXL345 controller's X/Y/Z outputs, alongside the LED controller.
//   On each sample strobe it snapshots X/Y/Z and streams one 8-byte telemetry frame out of a UART TX pin (8N1).

---
 rtl/adxl345_uart_reporter_pkg.sv | 46 ++++
 rtl/adxl345_uart_reporter_uart_tx_byte.sv | 109 ++++++++++
 rtl/adxl345_uart_reporter.sv | 110 +++++++++++
 3 files changed

// File: rtl/adxl345_uart_reporter_pkg.sv
// Shared definitions for the ADXL345 telemetry reporter: frame constants,
// state encodings and the frame byte selection helper.
package adxl345_uart_reporter_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int         FRAME_LEN = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_SEND,
        FR_DONE
    } frame_state_e;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
    } sample_t;

    function automatic logic [7:0] frame_chk(input sample_t s);
        return s.x[15:8] ^ s.x[7:0] ^ s.y[15:8] ^ s.y[7:0] ^ s.z[15:8] ^ s.z[7:0];
    endfunction

    function automatic logic [7:0] frame_byte(input logic [2:0] idx, input sample_t s);
        logic [7:0] b;
        case (idx)
            3'd0:    b = SYNC_BYTE;
            3'd1:    b = s.x[15:8];
            3'd2:    b = s.x[7:0];
            3'd3:    b = s.y[15:8];
            3'd4:    b = s.y[7:0];
            3'd5:    b = s.z[15:8];
            3'd6:    b = s.z[7:0];
            default: b = frame_chk(s);
        endcase
        return b;
    endfunction

endpackage

// File: rtl/adxl345_uart_reporter_uart_tx_byte.sv
// 8N1 byte serializer. A start request during the last stop-bit cycle chains
// the next byte with no idle gap; done_o pulses in that last stop-bit cycle.
module adxl345_uart_reporter_uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic [7:0] data_i,
    output logic       tx_o,
    output logic       done_o
);
    import adxl345_uart_reporter_pkg::*;

    localparam int              CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_o    = 1'b0;
        case (state_q)
            TX_IDLE: begin
                if (start_i) begin
                    state_d = TX_START;
                    cnt_d   = '0;
                    shift_d = data_i;
                end
            end
            TX_START: begin
                if (bit_end) begin
                    state_d   = TX_DATA;
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (bit_end) begin
                    done_o = 1'b1;
                    cnt_d  = '0;
                    if (start_i) begin
                        state_d = TX_START;
                        shift_d = data_i;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    // Line level is registered from the next state so the pin never glitches.
    always_comb begin
        case (state_d)
            TX_START: tx_d = 1'b0;
            TX_DATA:  tx_d = shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= TX_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            tx_q      <= tx_d;
        end
    end

    always_ff @(posedge clk_i) begin
        shift_q <= shift_d;
    end

    assign tx_o = tx_q;

endmodule

// File: rtl/adxl345_uart_reporter.sv
// Snapshots X/Y/Z on an accepted strobe and streams an 8-byte telemetry frame
// (sync, X, Y, Z big-endian, XOR checksum) over an 8N1 UART pin.
module adxl345_uart_reporter #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] X,
    input  logic [15:0] Y,
    input  logic [15:0] Z,
    input  logic        sample_valid,
    input  logic        enable,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  overrun_cnt
);
    import adxl345_uart_reporter_pkg::*;

    localparam int         CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [2:0] LAST_BYTE    = 3'(FRAME_LEN - 1);

    if (CLKS_PER_BIT < 2) begin : g_cpb_check
        $error("adxl345_uart_reporter: CLK_FREQ/BAUD must be at least 2");
    end

    frame_state_e fstate_q, fstate_d;
    logic [2:0]   byte_idx_q, byte_idx_d;
    logic [7:0]   overrun_q, overrun_d;
    sample_t      snap_q;
    logic         accept, drop;
    logic         tx_start, tx_done;
    logic [2:0]   tx_sel;
    logic [7:0]   tx_data;

    assign busy       = (fstate_q == FR_SEND);
    assign frame_done = (fstate_q == FR_DONE);
    assign accept     = sample_valid && enable && !busy;
    assign drop       = sample_valid && enable && busy;

    always_comb begin
        fstate_d   = fstate_q;
        byte_idx_d = byte_idx_q;
        overrun_d  = overrun_q;
        tx_start   = 1'b0;
        tx_sel     = byte_idx_q;
        case (fstate_q)
            FR_SEND: begin
                if (tx_done) begin
                    if (byte_idx_q == LAST_BYTE) begin
                        fstate_d = FR_DONE;
                    end else begin
                        tx_start   = 1'b1;
                        tx_sel     = byte_idx_q + 3'd1;
                        byte_idx_d = byte_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                // The DONE cycle accepts like IDLE so back-to-back frames lose no strobe.
                if (accept) begin
                    fstate_d   = FR_SEND;
                    tx_start   = 1'b1;
                    tx_sel     = 3'd0;
                    byte_idx_d = 3'd0;
                end else begin
                    fstate_d = FR_IDLE;
                end
            end
        endcase
        if (drop && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fstate_q   <= FR_IDLE;
            byte_idx_q <= 3'd0;
            overrun_q  <= 8'd0;
        end else begin
            fstate_q   <= fstate_d;
            byte_idx_q <= byte_idx_d;
            overrun_q  <= overrun_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            snap_q <= {X, Y, Z};
        end
    end

    // Byte 0 is the constant sync byte, so the not-yet-loaded snapshot is never read on accept.
    assign tx_data     = frame_byte(tx_sel, snap_q);
    assign overrun_cnt = overrun_q;

    adxl345_uart_reporter_uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk_i  (clk),
        .reset_i(reset),
        .start_i(tx_start),
        .data_i (tx_data),
        .tx_o   (tx),
        .done_o (tx_done)
    );

endmodule
